// File: rtl/verilog_literal_parser_pkg.sv
// Shared types and ASCII constants for the Verilog literal parser.
// Optional x/z support in the parser is controlled by LITERAL_PARSER_XZ_EN.
package verilog_literal_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_SIZE   = 3'd0;
    localparam state_t ST_BASE   = 3'd1;
    localparam state_t ST_DIGITS = 3'd2;
    localparam state_t ST_DRAIN  = 3'd3;
    localparam state_t ST_HOLD   = 3'd4;

    typedef enum logic [1:0] {
        BASE_BIN = 2'd0,
        BASE_OCT = 2'd1,
        BASE_DEC = 2'd2,
        BASE_HEX = 2'd3
    } base_e;

    localparam logic [7:0] CH_APOS  = 8'h27;
    localparam logic [7:0] CH_UNDER = 8'h5F;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_LA    = 8'h61;
    localparam logic [7:0] CH_LF    = 8'h66;
    localparam logic [7:0] CH_UA    = 8'h41;
    localparam logic [7:0] CH_UZ    = 8'h5A;
    localparam logic [7:0] CH_LB    = 8'h62;
    localparam logic [7:0] CH_LO    = 8'h6F;
    localparam logic [7:0] CH_LD    = 8'h64;
    localparam logic [7:0] CH_LH    = 8'h68;
    localparam logic [7:0] CH_LX    = 8'h78;
    localparam logic [7:0] CH_LZ    = 8'h7A;
    localparam logic [7:0] CH_QM    = 8'h3F;

    // Fold upper-case letters so base and hex digits are case-insensitive.
    function automatic logic [7:0] to_lower(input logic [7:0] c);
        return (c >= CH_UA && c <= CH_UZ) ? (c | 8'h20) : c;
    endfunction

endpackage

// File: rtl/verilog_literal_parser_if.sv
// Character-in / result-out stream bundle for the literal parser.
// out_xmask exists only when LITERAL_PARSER_XZ_EN is defined.
interface verilog_literal_parser_if #(
    parameter int unsigned MAX_WIDTH = 32,
    parameter int unsigned WW        = $clog2(MAX_WIDTH + 1)
);
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [MAX_WIDTH-1:0] out_value;
    logic [WW-1:0]        out_width;
    logic                 out_error;
`ifdef LITERAL_PARSER_XZ_EN
    logic [MAX_WIDTH-1:0] out_xmask;

    modport master (output in_valid, in_data, in_last, out_ready,
                    input  in_ready, out_valid, out_value, out_width, out_error, out_xmask);
    modport slave  (input  in_valid, in_data, in_last, out_ready,
                    output in_ready, out_valid, out_value, out_width, out_error, out_xmask);
`else
    modport master (output in_valid, in_data, in_last, out_ready,
                    input  in_ready, out_valid, out_value, out_width, out_error);
    modport slave  (input  in_valid, in_data, in_last, out_ready,
                    output in_ready, out_valid, out_value, out_width, out_error);
`endif
endinterface

// File: rtl/verilog_literal_parser_digit_decode.sv
// Combinational ASCII digit classifier for a given base.
// x/z/? digits are recognised only when LITERAL_PARSER_XZ_EN is defined.
module literal_digit_decode
    import verilog_literal_pkg::*;
(
    input  logic [7:0] ch_i,
    input  base_e      base_i,
    output logic [3:0] digit_c_o,
    output logic       legal_c_o,
    output logic       under_c_o
`ifdef LITERAL_PARSER_XZ_EN
   ,output logic       is_x_c_o,
    output logic       is_z_c_o
`endif
);

    logic [7:0] lc;
    logic       is_num;

    always_comb begin
        lc        = to_lower(ch_i);
        is_num    = 1'b0;
        digit_c_o = 4'd0;
        legal_c_o = 1'b0;
        under_c_o = 1'b0;
`ifdef LITERAL_PARSER_XZ_EN
        is_x_c_o  = 1'b0;
        is_z_c_o  = 1'b0;
`endif
        if (lc >= CH_0 && lc <= CH_9) begin
            is_num    = 1'b1;
            digit_c_o = 4'(lc - CH_0);
        end else if (lc >= CH_LA && lc <= CH_LF) begin
            is_num    = 1'b1;
            digit_c_o = 4'(lc - CH_LA + 8'd10);
        end else if (lc == CH_UNDER) begin
            under_c_o = 1'b1;
        end
`ifdef LITERAL_PARSER_XZ_EN
        else if (lc == CH_LX) begin
            is_x_c_o = 1'b1;
        end else if (lc == CH_LZ || lc == CH_QM) begin
            // z drives every value bit of the digit to 1
            is_z_c_o  = 1'b1;
            digit_c_o = (base_i == BASE_HEX) ? 4'hF : (base_i == BASE_OCT) ? 4'h7 : 4'h1;
        end
`endif
        case (base_i)
            BASE_BIN: legal_c_o = is_num && (digit_c_o < 4'd2);
            BASE_OCT: legal_c_o = is_num && (digit_c_o < 4'd8);
            BASE_DEC: legal_c_o = is_num && (digit_c_o < 4'd10);
            default:  legal_c_o = is_num;
        endcase
`ifdef LITERAL_PARSER_XZ_EN
        if ((is_x_c_o || is_z_c_o) && base_i != BASE_DEC) legal_c_o = 1'b1;
`endif
    end

endmodule

// File: rtl/verilog_literal_parser.sv
// Streaming parser from Verilog number literals (sized/unsized) to binary values.
// Define LITERAL_PARSER_XZ_EN to accept x/z/? digits and produce out_xmask.
module verilog_literal_parser
    import verilog_literal_pkg::*;
#(
    parameter int unsigned MAX_WIDTH = 32,
    parameter int unsigned WW        = $clog2(MAX_WIDTH + 1)
) (
    input logic                     clk,
    input logic                     rst_n,
    verilog_literal_parser_if.slave bus
);

    localparam int unsigned AW = MAX_WIDTH + 4;

    state_t               state_q, state_d;
    base_e                base_q, base_d, dec_base, base_sel;
    logic [MAX_WIDTH-1:0] acc_q, acc_d;
    logic [WW-1:0]        size_q, size_d;
    logic                 ovf_q, ovf_d, err_q, err_d, sized_q, sized_d, any_q, any_d;
    logic                 out_valid_q, out_valid_d, out_error_q, out_error_d;
    logic [MAX_WIDTH-1:0] out_value_q, out_value_d;
    logic [WW-1:0]        out_width_q, out_width_d;
    logic [AW-1:0]        acc_ext, prod, mask_ext, fin_ext;
    logic [3:0]           digit;
    logic                 legal, under, prod_ovf, accept, finish, fin_err, base_ok, size_bad;
    logic [7:0]           lc;
`ifdef LITERAL_PARSER_XZ_EN
    logic [MAX_WIDTH-1:0] xmask_q, xmask_d, out_xmask_q, out_xmask_d;
    logic [AW-1:0]        xm_ext, xprod;
    logic                 is_x, is_z;
`endif

    // Size field is always decimal.
    assign dec_base = (state_q == ST_SIZE) ? BASE_DEC : base_q;
    assign accept   = bus.in_valid && !out_valid_q;
    assign lc       = to_lower(bus.in_data);

    literal_digit_decode u_decode (
        .ch_i      (bus.in_data),
        .base_i    (dec_base),
        .digit_c_o (digit),
        .legal_c_o (legal),
        .under_c_o (under)
`ifdef LITERAL_PARSER_XZ_EN
       ,.is_x_c_o  (is_x),
        .is_z_c_o  (is_z)
`endif
    );

    // Next accumulator value with headroom to detect bits at/above MAX_WIDTH.
    always_comb begin
        acc_ext = AW'(acc_q);
        case (dec_base)
            BASE_BIN: prod = (acc_ext << 1) | AW'(digit);
            BASE_OCT: prod = (acc_ext << 3) | AW'(digit);
            BASE_HEX: prod = (acc_ext << 4) | AW'(digit);
            default:  prod = acc_ext * AW'(10) + AW'(digit);
        endcase
        prod_ovf = |prod[AW-1:MAX_WIDTH];
`ifdef LITERAL_PARSER_XZ_EN
        xm_ext = AW'(xmask_q);
        case (dec_base)
            BASE_BIN: xprod = (xm_ext << 1) | AW'({3'd0, is_x | is_z});
            BASE_OCT: xprod = (xm_ext << 3) | AW'((is_x | is_z) ? 4'h7 : 4'h0);
            BASE_HEX: xprod = (xm_ext << 4) | AW'((is_x | is_z) ? 4'hF : 4'h0);
            default:  xprod = xm_ext;
        endcase
`endif
    end

    always_comb begin
        base_ok  = 1'b1;
        base_sel = BASE_BIN;
        case (lc)
            CH_LB:   base_sel = BASE_BIN;
            CH_LO:   base_sel = BASE_OCT;
            CH_LD:   base_sel = BASE_DEC;
            CH_LH:   base_sel = BASE_HEX;
            default: base_ok  = 1'b0;
        endcase
    end

    assign size_bad = ovf_q || (acc_q > MAX_WIDTH'(MAX_WIDTH));

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        sized_d     = sized_q;
        any_d       = any_q;
        size_d      = size_q;
        out_valid_d = out_valid_q;
        out_value_d = out_value_q;
        out_width_d = out_width_q;
        out_error_d = out_error_q;
`ifdef LITERAL_PARSER_XZ_EN
        xmask_d     = xmask_q;
        out_xmask_d = out_xmask_q;
`endif
        finish   = 1'b0;
        fin_err  = 1'b0;
        mask_ext = '0;
        fin_ext  = '0;

        if (state_q == ST_HOLD) begin
            if (bus.out_ready) begin
                out_valid_d = 1'b0;
                state_d     = ST_SIZE;
            end
        end else if (accept) begin
            case (state_q)
                ST_SIZE: begin
                    if (legal) begin
                        acc_d = prod[MAX_WIDTH-1:0];
                        ovf_d = ovf_q | prod_ovf;
                        any_d = 1'b1;
                    end else if (bus.in_data == CH_APOS) begin
                        if (size_bad || acc_q == '0) err_d = 1'b1;
                        size_d  = size_bad ? WW'(MAX_WIDTH) : WW'(acc_q);
                        sized_d = 1'b1;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        any_d   = 1'b0;
                        state_d = ST_BASE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
                ST_BASE: begin
                    if (base_ok) begin
                        base_d  = base_sel;
                        state_d = ST_DIGITS;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
                ST_DIGITS: begin
                    if (legal) begin
                        acc_d = prod[MAX_WIDTH-1:0];
                        ovf_d = ovf_q | prod_ovf;
                        any_d = 1'b1;
`ifdef LITERAL_PARSER_XZ_EN
                        xmask_d = xprod[MAX_WIDTH-1:0];
`endif
                    end else if (!(under && any_q)) begin
                        err_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
                default: ;
            endcase
            finish = bus.in_last;
        end

        // Publish the result and rearm the token state in one step.
        if (finish) begin
            mask_ext = (AW'(1) << size_d) - AW'(1);
            fin_ext  = AW'(acc_d);
            fin_err  = err_d || ovf_d || (sized_d && !any_d)
                    || (sized_d && ((fin_ext & ~mask_ext) != '0));
            out_valid_d = 1'b1;
            out_error_d = fin_err;
            out_width_d = sized_d ? size_d : '0;
            out_value_d = sized_d ? MAX_WIDTH'(fin_ext & mask_ext) : acc_d;
`ifdef LITERAL_PARSER_XZ_EN
            out_xmask_d = sized_d ? MAX_WIDTH'(AW'(xmask_d) & mask_ext) : xmask_d;
            xmask_d     = '0;
`endif
            state_d = ST_HOLD;
            acc_d   = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
            sized_d = 1'b0;
            any_d   = 1'b0;
            size_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_SIZE;
            base_q      <= BASE_BIN;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            sized_q     <= 1'b0;
            any_q       <= 1'b0;
            size_q      <= '0;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            out_width_q <= '0;
            out_error_q <= 1'b0;
`ifdef LITERAL_PARSER_XZ_EN
            xmask_q     <= '0;
            out_xmask_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            sized_q     <= sized_d;
            any_q       <= any_d;
            size_q      <= size_d;
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
            out_width_q <= out_width_d;
            out_error_q <= out_error_d;
`ifdef LITERAL_PARSER_XZ_EN
            xmask_q     <= xmask_d;
            out_xmask_q <= out_xmask_d;
`endif
        end
    end

    assign bus.in_ready  = !out_valid_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_value = out_value_q;
    assign bus.out_width = out_width_q;
    assign bus.out_error = out_error_q;
`ifdef LITERAL_PARSER_XZ_EN
    assign bus.out_xmask = out_xmask_q;
`endif

endmodule

// File: tb/tb_verilog_literal_parser.sv
// Directed bench for verilog_literal_parser with MAX_WIDTH=32.
// Checks x/z handling when built with LITERAL_PARSER_XZ_EN.
module tb_verilog_literal_parser;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    verilog_literal_parser_if #(.MAX_WIDTH(32)) bus ();

    verilog_literal_parser #(.MAX_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Feed a string one character per accepted cycle; caller sits 1 time unit after an edge.
    task automatic send_token(input string s, input bit term);
        int n;
        for (int i = 0; i < s.len(); i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = s[i];
            bus.in_last  = term && (i == s.len() - 1);
            n = 0;
            while (!bus.in_ready && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 20) begin
                fails++;
                $display("FAIL send_timeout token=%s in_ready stuck at %b, want 1", s, bus.in_ready);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Snapshot the outputs, then complete the handshake with one out_ready cycle.
    task automatic take(output logic vld, output logic [31:0] v, output logic [5:0] w, output logic e);
        vld = bus.out_valid;
        v   = bus.out_value;
        w   = bus.out_width;
        e   = bus.out_error;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", bus.out_valid); end
        tests++; if (bus.out_value !== 32'd0) begin fails++; $display("FAIL rst_value got %h want 0", bus.out_value); end
        tests++; if (bus.out_width !== 6'd0) begin fails++; $display("FAIL rst_width got %0d want 0", bus.out_width); end
        tests++; if (bus.out_error !== 1'b0) begin fails++; $display("FAIL rst_error got %b want 0", bus.out_error); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_sized_hex();
        logic vld, e; logic [31:0] v; logic [5:0] w;
        send_token("5'h13", 1'b1);
        take(vld, v, w, e);
        tests++; if (vld !== 1'b1) begin fails++; $display("FAIL h13_latency valid got %b want 1", vld); end
        tests++; if (v !== 32'h13) begin fails++; $display("FAIL h13_value got %h want 13", v); end
        tests++; if (w !== 6'd5) begin fails++; $display("FAIL h13_width got %0d want 5", w); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL h13_error got %b want 0", e); end
    endtask

    task automatic test_back_to_back();
        logic vld, e; logic [31:0] v; logic [5:0] w;
        send_token("2'b01", 1'b1);
        take(vld, v, w, e);
        tests++; if (vld !== 1'b1 || v !== 32'd1 || w !== 6'd2 || e !== 1'b0) begin
            fails++; $display("FAIL b01 got v=%b val=%h w=%0d e=%b want 1 1 2 0", vld, v, w, e); end
        send_token("0101", 1'b1);
        take(vld, v, w, e);
        tests++; if (vld !== 1'b1 || v !== 32'd101 || w !== 6'd0 || e !== 1'b0) begin
            fails++; $display("FAIL unsized0101 got v=%b val=%0d w=%0d e=%b want 1 101 0 0", vld, v, w, e); end
    endtask

    task automatic test_errors();
        logic vld, e; logic [31:0] v; logic [5:0] w;
        send_token("4'hff", 1'b1);
        take(vld, v, w, e);
        tests++; if (vld !== 1'b1 || e !== 1'b1 || w !== 6'd4 || v !== 32'hF) begin
            fails++; $display("FAIL hff_over got v=%b e=%b w=%0d val=%h want 1 1 4 f", vld, e, w, v); end
        send_token("0'h1", 1'b1);
        take(vld, v, w, e);
        tests++; if (e !== 1'b1) begin fails++; $display("FAIL size_zero error got %b want 1", e); end
        send_token("33'h0", 1'b1);
        take(vld, v, w, e);
        tests++; if (e !== 1'b1 || w !== 6'd32) begin
            fails++; $display("FAIL size_33 got e=%b w=%0d want 1 32", e, w); end
        send_token("4'h_1", 1'b1);
        take(vld, v, w, e);
        tests++; if (e !== 1'b1) begin fails++; $display("FAIL lead_under error got %b want 1", e); end
        send_token("8'hg1", 1'b1);
        take(vld, v, w, e);
        tests++; if (vld !== 1'b1 || e !== 1'b1 || w !== 6'd8) begin
            fails++; $display("FAIL bad_digit got v=%b e=%b w=%0d want 1 1 8", vld, e, w); end
        send_token("4294967296", 1'b1);
        take(vld, v, w, e);
        tests++; if (e !== 1'b1 || w !== 6'd0) begin
            fails++; $display("FAIL unsized_ovf got e=%b w=%0d want 1 0", e, w); end
        send_token("5'h", 1'b1);
        take(vld, v, w, e);
        tests++; if (vld !== 1'b1 || e !== 1'b1) begin
            fails++; $display("FAIL empty_digits got v=%b e=%b want 1 1", vld, e); end
        send_token("8'q1", 1'b1);
        take(vld, v, w, e);
        tests++; if (e !== 1'b1) begin fails++; $display("FAIL bad_base error got %b want 1", e); end
    endtask

    task automatic test_bases();
        logic vld, e; logic [31:0] v; logic [5:0] w;
        send_token("8'o17", 1'b1);
        take(vld, v, w, e);
        tests++; if (v !== 32'd15 || w !== 6'd8 || e !== 1'b0) begin
            fails++; $display("FAIL oct17 got val=%0d w=%0d e=%b want 15 8 0", v, w, e); end
        send_token("12'D100", 1'b1);
        take(vld, v, w, e);
        tests++; if (v !== 32'd100 || w !== 6'd12 || e !== 1'b0) begin
            fails++; $display("FAIL dec100 got val=%0d w=%0d e=%b want 100 12 0", v, w, e); end
        send_token("8'hA_b", 1'b1);
        take(vld, v, w, e);
        tests++; if (v !== 32'hAB || w !== 6'd8 || e !== 1'b0) begin
            fails++; $display("FAIL hexAb got val=%h w=%0d e=%b want ab 8 0", v, w, e); end
        send_token("4294967295", 1'b1);
        take(vld, v, w, e);
        tests++; if (v !== 32'hFFFF_FFFF || w !== 6'd0 || e !== 1'b0) begin
            fails++; $display("FAIL unsized_max got val=%h w=%0d e=%b want ffffffff 0 0", v, w, e); end
        send_token("32'hFFFFFFFF", 1'b1);
        take(vld, v, w, e);
        tests++; if (v !== 32'hFFFF_FFFF || w !== 6'd32 || e !== 1'b0) begin
            fails++; $display("FAIL sized_max got val=%h w=%0d e=%b want ffffffff 32 0", v, w, e); end
    endtask

    task automatic test_hold_stall();
        logic vld, e; logic [31:0] v; logic [5:0] w;
        send_token("5'h0_0", 1'b1);
        for (int i = 0; i < 3; i++) begin
            tests++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                fails++; $display("FAIL stall_hs cyc=%0d got valid=%b in_ready=%b want 1 0", i, bus.out_valid, bus.in_ready); end
            tests++; if (bus.out_value !== 32'd0 || bus.out_width !== 6'd5 || bus.out_error !== 1'b0) begin
                fails++; $display("FAIL stall_data cyc=%0d got val=%h w=%0d e=%b want 0 5 0", i, bus.out_value, bus.out_width, bus.out_error); end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL stall_release got valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready); end
        send_token("7", 1'b1);
        take(vld, v, w, e);
        tests++; if (vld !== 1'b1 || v !== 32'd7 || w !== 6'd0) begin
            fails++; $display("FAIL after_stall got v=%b val=%0d w=%0d want 1 7 0", vld, v, w); end
    endtask

    task automatic test_reset_abort();
        logic vld, e; logic [31:0] v; logic [5:0] w;
        send_token("5'h", 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL abort_novalid got %b want 0", bus.out_valid); end
        send_token("3'd7", 1'b1);
        take(vld, v, w, e);
        tests++; if (vld !== 1'b1 || v !== 32'd7 || w !== 6'd3 || e !== 1'b0) begin
            fails++; $display("FAIL abort_next got v=%b val=%0d w=%0d e=%b want 1 7 3 0", vld, v, w, e); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL abort_single got %b want 0", bus.out_valid); end
        send_token("1", 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL hold_reset got valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_xz();
        logic vld, e; logic [31:0] v; logic [5:0] w;
`ifdef LITERAL_PARSER_XZ_EN
        logic [31:0] xm;
        send_token("4'b1x0z", 1'b1);
        xm = bus.out_xmask;
        take(vld, v, w, e);
        tests++; if (v !== 32'h9 || w !== 6'd4 || e !== 1'b0) begin
            fails++; $display("FAIL xz_value got val=%h w=%0d e=%b want 9 4 0", v, w, e); end
        tests++; if (xm !== 32'h5) begin fails++; $display("FAIL xz_mask got %h want 5", xm); end
        send_token("4'd1x", 1'b1);
        take(vld, v, w, e);
        tests++; if (e !== 1'b1) begin fails++; $display("FAIL xz_decimal error got %b want 1", e); end
`else
        send_token("4'b1x0z", 1'b1);
        take(vld, v, w, e);
        tests++; if (vld !== 1'b1 || e !== 1'b1) begin
            fails++; $display("FAIL xz_disabled got v=%b e=%b want 1 1", vld, e); end
`endif
    endtask

    initial begin
        clk           = 1'b0;
        rst_n         = 1'b0;
        tests         = 0;
        fails         = 0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_sized_hex();
        test_back_to_back();
        test_errors();
        test_bases();
        test_hold_stall();
        test_reset_abort();
        test_xz();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
